// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port ids and
// the funct3-style size codes forwarded to the memory controller.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CORE   = 2'd1,
        DBG    = 2'd2,
        LOCKED = 2'd3
    } state_t;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DBG  = 1'b1
    } port_t;

    localparam logic [2:0] MC_BYTE  = 3'b000;
    localparam logic [2:0] MC_HALF  = 3'b001;
    localparam logic [2:0] MC_WORD  = 3'b010;
    localparam logic [2:0] MC_BYTEU = 3'b100;
    localparam logic [2:0] MC_HALFU = 3'b101;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick (bit 0 = core, bit 1 = debug) with a
// lock override that restricts the grant to the debug port.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rstN,
    input  logic [1:0] req,
    input  logic       lock,
    output logic [1:0] gnt
);

    port_t last_winner;

    always_comb begin
        gnt = 2'b00;
        if (lock)
            gnt = {req[1], 1'b0};
        else if (&req)
            gnt = (last_winner == PORT_DBG) ? 2'b01 : 2'b10;
        else
            gnt = req;
    end

    // Reset to debug so the core takes the first tie.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            last_winner <= PORT_DBG;
        else if (gnt[1])
            last_winner <= PORT_DBG;
        else if (gnt[0])
            last_winner <= PORT_CORE;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load-store port and the debug/loader
// port: combinational grant, single-cycle registered read response.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              cReq,
    input  logic              cWe,
    input  logic [2:0]        cMemCtrl,
    input  logic [31:0]       cAddr,
    input  logic [31:0]       cWData,
    output logic              cGnt,
    output logic              cRValid,
    output logic [31:0]       cRData,
    output logic              cStall,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [2:0]        dMemCtrl,
    input  logic [31:0]       dAddr,
    input  logic [31:0]       dWData,
    input  logic              dLock,
    output logic              dGnt,
    output logic              dRValid,
    output logic [31:0]       dRData,
    output logic [ADDR_W-1:0] mAddr,
    output logic [2:0]        mMemCtrl,
    output logic              mW,
    output logic [31:0]       mWData,
    input  logic [31:0]       mRData
);

    state_t     state_q, state_d;
    logic [1:0] gnt;

    rr_arb2 u_arb (
        .clk  (clk),
        .rstN (rstN),
        .req  ({dReq, cReq}),
        .lock (state_q == LOCKED),
        .gnt  (gnt)
    );

    assign cGnt   = gnt[0];
    assign dGnt   = gnt[1];
    assign cStall = cReq & ~cGnt;

    // State records this cycle's winner; a locked debug grant keeps the bus.
    always_comb begin
        state_d = IDLE;
        if (dGnt)
            state_d = dLock ? LOCKED : DBG;
        else if (cGnt)
            state_d = CORE;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        mAddr    = '0;
        mMemCtrl = '0;
        mWData   = '0;
        mW       = 1'b0;
        if (cGnt) begin
            mAddr    = cAddr[ADDR_W-1:0];
            mMemCtrl = cMemCtrl;
            mWData   = cWData;
            mW       = cWe & rstN;
        end else if (dGnt) begin
            mAddr    = dAddr[ADDR_W-1:0];
            mMemCtrl = dMemCtrl;
            mWData   = dWData;
            mW       = dWe & rstN;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cRValid <= 1'b0;
            dRValid <= 1'b0;
            cRData  <= '0;
            dRData  <= '0;
        end else begin
            cRValid <= cGnt & ~cWe;
            dRValid <= dGnt & ~dWe;
            if (cGnt & ~cWe)
                cRData <= mRData;
            if (dGnt & ~dWe)
                dRData <= mRData;
        end
    end

    // Upper address bits are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{cAddr[31:ADDR_W], dAddr[31:ADDR_W]};

endmodule
